beamformer_sequencer: RTL
=========================

# beamformer_sequencer

Top-level sequencer for the BRAM delay-and-sum beamformer datapath. It counts filtered samples from the band-pass filter into the 96-bit input RAM, then sweeps that RAM once per 32-bit channel slice while driving sample index and slice select into the delay beamformer. Finally it streams the 10-bit-addressed sum RAM out to a consumer under a ready handshake. It sits between the system control logic and the beamformer datapath and replaces the ad-hoc address and strobe generation now done in the testbench.

## Interface
- N_IN, 1800: filtered samples captured per frame (≤ 2048).
- N_OUT, 540: beamformed output words per frame (≤ 1024).
- RD_LAT, 1: input-RAM read latency in clocks.
- DRAIN, 4: idle clocks after each slice sweep for the beamformer pipeline to flush.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- go  in  1  one-cycle frame start request; honoured only in IDLE.
- filt_valid  in  1  filter output valid; one RAM word per high cycle.
- out_ready  in  1  consumer ready during readout.
- readin_address  out  11  input-RAM address (write during CAPTURE, read during SWEEP).
- output_read_en  out  1  input-RAM read enable.
- startbeamformer  out  1  high for the whole SWEEP/DRAIN span of all three slices.
- sample_index  out  16  index of the word currently on RAM q (address delayed by RD_LAT).
- slice_state  out  2  0 idle, 1..3 selects bits [31:0]/[63:32]/[95:64]; delayed with sample_index.
- sumout_address  out  10  sum-RAM read address.
- sumouten  out  1  sum-RAM read enable.
- result_valid  out  1  sum-RAM q is valid this cycle (sumouten delayed 1).
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE → CAPTURE → SWEEP → DRAIN → (SWEEP for next slice | READOUT) → IDLE.
- IDLE: all strobes low. go=1 clears counters and enters CAPTURE. filt_valid is ignored.
- CAPTURE: readin_address is the write pointer. It increments on each filt_valid, starting at 0. The pointer does not drive write enable, because RAM wren is filt_valid. When filt_valid is accepted at address N_IN-1, the address returns to 0, slice becomes 1 and the state moves to SWEEP. Further filt_valid pulses are ignored until the next frame.
- SWEEP: output_read_en=1 and readin_address counts 0..N_IN-1, one per clock. At N_IN-1 the state moves to DRAIN.
- Delay line: sample_index and slice_state are the readin_address and slice values delayed RD_LAT clocks. Outside the valid window they hold slice_state=0 and sample_index=16'hFFFF.
- DRAIN: counts DRAIN+RD_LAT clocks. It then increments slice and returns to SWEEP if slice<3. Otherwise it drops startbeamformer and enters READOUT.
- READOUT: sumouten = out_ready. sumout_address increments on each cycle with sumouten=1. After the read at address N_OUT-1 the state returns to IDLE, and frame_done pulses on the cycle result_valid is high for that last word.
- Widths: counters are unsigned with no wrap beyond the parameter limits. sample_index is zero-extended from 11 bits.

## Timing
- Reset values: readin_address=0, output_read_en=0, startbeamformer=0, sample_index=16'hFFFF, slice_state=0, sumout_address=0, sumouten=0, result_valid=0, busy=0, frame_done=0.
- Reset asserted in any state forces the reset values on the next edge. A partially processed frame is discarded.
- go and the last filt_valid arriving on the same cycle cannot occur, because go is ignored while busy.
- Latency from go to first SWEEP read is N_IN filt_valid pulses plus 1 clock.
- Each slice takes N_IN + DRAIN + RD_LAT clocks.
- The readout stream stalls exactly while out_ready=0. Address and result_valid hold with no gaps or duplicates.
- result_valid follows sumouten by exactly 1 clock.

## Structure
- A shared package beamformer_pkg holds:
  - state encoding: IDLE, CAPTURE, SWEEP, DRAIN, READOUT;
  - slice codes SLICE_IDLE=0, SLICE1..3;
  - default N_IN and N_OUT.
- One natural sub-module is bf_delay_line: a RD_LAT-deep register for {slice, address} with reset to the idle pattern.

## Test plan
- Reset mid-SWEEP (slice 2, address 700) → next cycle all outputs at reset values; busy=0.
- go, then 1800 filt_valid pulses with random gaps → readin_address steps 0..1799, ending at 0. SWEEP starts the next cycle and the extra valids are ignored.
- Full frame with RD_LAT=1 → sample_index equals the previous cycle's readin_address. slice_state shows 1, 2, 3 in turn, each for exactly 1800 cycles, separated by 5 idle cycles.
- READOUT with out_ready toggling 1,0,0,1… → sumout_address covers 0..539 exactly once and result_valid follows sumouten by 1 cycle.
- go asserted during CAPTURE and during READOUT → no effect on counters or state.
- N_IN=4, N_OUT=3 small-parameter frame → exact cycle count from go to frame_done matches the formula in Timing.

Source files
------------

// File: rtl/beamformer_pkg.sv
// Shared types and constants for the beamformer sequencer and its delay line.
// State encoding, slice select codes and default frame sizes live here.
package beamformer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SWEEP   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    localparam logic [1:0] SLICE_IDLE = 2'd0;
    localparam logic [1:0] SLICE1     = 2'd1;
    localparam logic [1:0] SLICE2     = 2'd2;
    localparam logic [1:0] SLICE3     = 2'd3;

    localparam int N_IN_DEFAULT  = 1800;
    localparam int N_OUT_DEFAULT = 540;

    // sample_index value shown whenever no RAM word is in flight
    localparam logic [15:0] IDLE_INDEX = 16'hFFFF;

    function automatic logic [15:0] idx_ext(input logic [10:0] addr);
        return {5'd0, addr};
    endfunction

endpackage

// File: rtl/bf_delay_line.sv
// Aligns {slice, address} with the input-RAM read data by delaying it DEPTH clocks.
// Cycles without a read carry the idle pattern (slice 0, index 16'hFFFF).
module bf_delay_line
    import beamformer_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [1:0]  i_slice,
    input  logic [10:0] i_addr,
    output logic [1:0]  o_slice,
    output logic [15:0] o_index
);

    localparam logic [17:0] IDLE_PAT = {SLICE_IDLE, IDLE_INDEX};

    logic [17:0] r_pipe [DEPTH];
    logic [17:0] w_in;

    assign w_in = i_valid ? {i_slice, idx_ext(i_addr)} : IDLE_PAT;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= IDLE_PAT;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_slice, o_index} = r_pipe[DEPTH-1];

endmodule

// File: rtl/beamformer_sequencer.sv
// Frame sequencer: capture filtered samples, sweep the input RAM once per
// 32-bit slice with a pipeline drain after each, then stream out the sum RAM.
module beamformer_sequencer
    import beamformer_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int N_OUT  = N_OUT_DEFAULT,
    parameter int RD_LAT = 1,
    parameter int DRAIN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        filt_valid,
    input  logic        out_ready,
    output logic [10:0] readin_address,
    output logic        output_read_en,
    output logic        startbeamformer,
    output logic [15:0] sample_index,
    output logic [1:0]  slice_state,
    output logic [9:0]  sumout_address,
    output logic        sumouten,
    output logic        result_valid,
    output logic        busy,
    output logic        frame_done,
    output state_t      o_dbg_state
);

    localparam logic [10:0] LAST_IN    = 11'(N_IN - 1);
    localparam logic [9:0]  LAST_OUT   = 10'(N_OUT - 1);
    localparam logic [7:0]  LAST_DRAIN = 8'(DRAIN + RD_LAT - 1);

    state_t      r_state;
    logic [10:0] r_addr;
    logic [1:0]  r_slice;
    logic [7:0]  r_drain_cnt;
    logic [9:0]  r_sum_addr;
    logic        r_result_valid;
    logic        r_frame_done;

    state_t      w_state_next;
    logic [10:0] w_addr_next;
    logic [1:0]  w_slice_next;
    logic [7:0]  w_drain_next;
    logic [9:0]  w_sum_addr_next;
    logic        w_sumouten;
    logic        w_last_read;

    // Readout handshake: a sum-RAM read is issued in every READOUT cycle with
    // out_ready high (sumouten); its data is flagged by result_valid one clock later.
    assign w_sumouten  = (r_state == ST_READOUT) && out_ready;
    assign w_last_read = w_sumouten && (r_sum_addr == LAST_OUT);

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_slice_next    = r_slice;
        w_drain_next    = r_drain_cnt;
        w_sum_addr_next = r_sum_addr;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_state_next    = ST_CAPTURE;
                    w_addr_next     = '0;
                    w_slice_next    = SLICE_IDLE;
                    w_drain_next    = '0;
                    w_sum_addr_next = '0;
                end
            end
            ST_CAPTURE: begin
                if (filt_valid) begin
                    if (r_addr == LAST_IN) begin
                        w_state_next = ST_SWEEP;
                        w_addr_next  = '0;
                        w_slice_next = SLICE1;
                    end else begin
                        w_addr_next = r_addr + 11'd1;
                    end
                end
            end
            ST_SWEEP: begin
                if (r_addr == LAST_IN) begin
                    w_state_next = ST_DRAIN;
                    w_addr_next  = '0;
                    w_drain_next = '0;
                end else begin
                    w_addr_next = r_addr + 11'd1;
                end
            end
            ST_DRAIN: begin
                // Drain covers the beamformer flush plus the RAM read latency
                if (r_drain_cnt == LAST_DRAIN) begin
                    w_drain_next = '0;
                    if (r_slice == SLICE3) begin
                        w_state_next    = ST_READOUT;
                        w_slice_next    = SLICE_IDLE;
                        w_sum_addr_next = '0;
                    end else begin
                        w_state_next = ST_SWEEP;
                        w_slice_next = r_slice + 2'd1;
                    end
                end else begin
                    w_drain_next = r_drain_cnt + 8'd1;
                end
            end
            ST_READOUT: begin
                if (w_sumouten) begin
                    if (w_last_read) begin
                        w_state_next    = ST_IDLE;
                        w_sum_addr_next = '0;
                    end else begin
                        w_sum_addr_next = r_sum_addr + 10'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_slice        <= SLICE_IDLE;
            r_drain_cnt    <= '0;
            r_sum_addr     <= '0;
            r_result_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_addr         <= w_addr_next;
            r_slice        <= w_slice_next;
            r_drain_cnt    <= w_drain_next;
            r_sum_addr     <= w_sum_addr_next;
            r_result_valid <= w_sumouten;
            r_frame_done   <= w_last_read;
        end
    end

    bf_delay_line #(
        .DEPTH (RD_LAT)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .i_valid (output_read_en),
        .i_slice (r_slice),
        .i_addr  (r_addr),
        .o_slice (slice_state),
        .o_index (sample_index)
    );

    assign readin_address  = r_addr;
    assign output_read_en  = (r_state == ST_SWEEP);
    assign startbeamformer = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign sumout_address  = r_sum_addr;
    assign sumouten        = w_sumouten;
    assign result_valid    = r_result_valid;
    assign busy            = (r_state != ST_IDLE);
    assign frame_done      = r_frame_done;
    assign o_dbg_state     = r_state;

endmodule
